// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one memory-side miss port between the I-cache refill path
//   (requester 0) and the D-cache refill path (requester 1). A round-robin
//   arbiter fills a single registered request slot. Memory answers in issue
//   order, so a small grant-order FIFO of requester IDs routes each response
//   back to whoever issued it.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ic_req_*                   I-cache miss request (valid/addr in, ready out)
//   dc_req_*                   D-cache miss request (valid/addr in, ready out)
//   mem_req_valid_o/addr_o     registered request towards memory
//   mem_req_ready_i            memory accepts the request in the slot
//   mem_resp_valid_i/data_i    in-order response line from memory
//   ic_resp_valid_o            response belongs to the I-cache
//   dc_resp_valid_o            response belongs to the D-cache
//   resp_data_o                response line, shared by both requesters
//   outstanding_o              number of issued, unanswered transactions
//   resp_err_o                 sticky: response arrived with nothing outstanding
//
// Optional build macro
//   MEM_ARB_PERF_CNT_EN adds ic_grant_cnt_o, dc_grant_cnt_o and
//   full_stall_cnt_o (32-bit wrapping event counters).

module mem_req_arbiter #(
  parameter int ADDR_W    = 26,
  parameter int LINE_W    = 256,
  parameter int ORD_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ic_req_valid_i,
  input  logic [ADDR_W-1:0]              ic_req_addr_i,
  output logic                           ic_req_ready_o,
  input  logic                           dc_req_valid_i,
  input  logic [ADDR_W-1:0]              dc_req_addr_i,
  output logic                           dc_req_ready_o,
  output logic                           mem_req_valid_o,
  output logic [ADDR_W-1:0]              mem_req_addr_o,
  input  logic                           mem_req_ready_i,
  input  logic                           mem_resp_valid_i,
  input  logic [LINE_W-1:0]              mem_resp_data_i,
  output logic                           ic_resp_valid_o,
  output logic                           dc_resp_valid_o,
  output logic [LINE_W-1:0]              resp_data_o,
  output logic [$clog2(ORD_DEPTH):0]     outstanding_o,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [31:0]                    ic_grant_cnt_o,
  output logic [31:0]                    dc_grant_cnt_o,
  output logic [31:0]                    full_stall_cnt_o,
`endif
  output logic                           resp_err_o
);

  localparam int PTR_W = $clog2(ORD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(ORD_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_XC = (CNT_W+1)'(ORD_DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

  slot_state_t              state, state_nxt;
  logic [ADDR_W-1:0]        addr_q;
  logic                     slot_id;
  logic                     last_grant;
  logic [ORD_DEPTH-1:0]     ord_id;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     err_q;

  logic                     any_req;
  logic                     push, pop;
  logic                     grant_en;
  logic                     grant_ic, grant_dc;
  logic [CNT_W:0]           count_after;

  assign any_req = ic_req_valid_i | dc_req_valid_i;
  assign push    = (state == S_FULL) && mem_req_ready_i;
  assign pop     = mem_resp_valid_i && (count != '0);

  // Occupancy once this cycle's handshake and response have both landed;
  // a reload from FULL is only allowed if that still leaves room.
  assign count_after = {1'b0, count} + (CNT_W+1)'(1) - {{CNT_W{1'b0}}, pop};

  // Slot FSM: EMPTY grants whenever the order FIFO has room; FULL can only
  // grant in the cycle its held request is handshaken, so the slot refills
  // back-to-back without a bubble. Grants are blocked while reset is high.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      S_EMPTY: begin
        grant_en = !reset && (count != DEPTH_C);
        if (grant_en && any_req) state_nxt = S_FULL;
      end
      S_FULL: begin
        if (mem_req_ready_i) begin
          grant_en = !reset && (count_after < DEPTH_XC);
          if (!(grant_en && any_req)) state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Round-robin: on a tie the requester that did not win last time goes.
  assign grant_ic = grant_en && ic_req_valid_i && (!dc_req_valid_i || last_grant);
  assign grant_dc = grant_en && dc_req_valid_i && (!ic_req_valid_i || !last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  // Slot contents and round-robin history update on every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      slot_id    <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_ic) begin
      addr_q     <= ic_req_addr_i;
      slot_id    <= 1'b0;
      last_grant <= 1'b0;
    end else if (grant_dc) begin
      addr_q     <= dc_req_addr_i;
      slot_id    <= 1'b1;
      last_grant <= 1'b1;
    end
  end

  // Grant-order FIFO; pointers wrap naturally since the depth is a power of 2
  // and the extra count bit tells full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ord_id <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ord_id[wr_ptr] <= slot_id;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   err_q <= 1'b0;
    else if (mem_resp_valid_i && (count == '0))  err_q <= 1'b1;
  end

  assign ic_req_ready_o  = grant_ic;
  assign dc_req_ready_o  = grant_dc;
  assign mem_req_valid_o = (state == S_FULL);
  assign mem_req_addr_o  = addr_q;
  assign ic_resp_valid_o = pop && !ord_id[rd_ptr];
  assign dc_resp_valid_o = pop &&  ord_id[rd_ptr];
  assign resp_data_o     = mem_resp_data_i;
  assign outstanding_o   = count;
  assign resp_err_o      = err_q;

`ifdef MEM_ARB_PERF_CNT_EN
  // Event counters: grants per requester, and cycles where someone wanted
  // the port but the order FIFO was full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ic_grant_cnt_o   <= '0;
      dc_grant_cnt_o   <= '0;
      full_stall_cnt_o <= '0;
    end else begin
      if (grant_ic) ic_grant_cnt_o <= ic_grant_cnt_o + 32'd1;
      if (grant_dc) dc_grant_cnt_o <= dc_grant_cnt_o + 32'd1;
      if (any_req && (count == DEPTH_C)) full_stall_cnt_o <= full_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//   Randomised bench for mem_req_arbiter. A reference model built from
//   queues (requests waiting in the slot, IDs waiting for a response)
//   predicts grants, memory requests, routing and the outstanding count.
//   The stimulus process only drives inputs; the monitor process on the
//   falling edge compares and advances the model.

module tb_mem_req_arbiter;

  localparam int ADDR_W    = 26;
  localparam int LINE_W    = 256;
  localparam int ORD_DEPTH = 4;
  localparam int CNT_W     = $clog2(ORD_DEPTH) + 1;

  typedef struct {
    bit                id;
    logic [ADDR_W-1:0] addr;
  } req_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              icValid, dcValid;
  logic [ADDR_W-1:0] icAddr, dcAddr;
  logic              icReady, dcReady;
  logic              memReqValid;
  logic [ADDR_W-1:0] memReqAddr;
  logic              memReady;
  logic              respValid;
  logic [LINE_W-1:0] respData;
  logic              icRespValid, dcRespValid;
  logic [LINE_W-1:0] respDataOut;
  logic [CNT_W-1:0]  outstanding;
  logic              respErr;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]       icGrantCnt, dcGrantCnt, fullStallCnt;
`endif

  // Model state
  req_t  reqQ[$];
  bit    routeQ[$];
  bit    lastGrant = 1'b1;
  bit    expErr    = 1'b0;
  bit    icAcc     = 1'b0;
  bit    dcAcc     = 1'b0;

  // Snapshot taken shortly after an asynchronous reset assertion
  bit              asyncSnapValid = 1'b0;
  logic [CNT_W+5:0] asyncSnap;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .ORD_DEPTH(ORD_DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .ic_req_valid_i   (icValid),
    .ic_req_addr_i    (icAddr),
    .ic_req_ready_o   (icReady),
    .dc_req_valid_i   (dcValid),
    .dc_req_addr_i    (dcAddr),
    .dc_req_ready_o   (dcReady),
    .mem_req_valid_o  (memReqValid),
    .mem_req_addr_o   (memReqAddr),
    .mem_req_ready_i  (memReady),
    .mem_resp_valid_i (respValid),
    .mem_resp_data_i  (respData),
    .ic_resp_valid_o  (icRespValid),
    .dc_resp_valid_o  (dcRespValid),
    .resp_data_o      (respDataOut),
    .outstanding_o    (outstanding),
`ifdef MEM_ARB_PERF_CNT_EN
    .ic_grant_cnt_o   (icGrantCnt),
    .dc_grant_cnt_o   (dcGrantCnt),
    .full_stall_cnt_o (fullStallCnt),
`endif
    .resp_err_o       (respErr)
  );

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model.
  always @(negedge clk) begin
    int   outs;
    bit   slotFull, hs, pop, canGrant, expIc, expDc, id;
    req_t r;
    if (reset) begin
      checkOutput("rst_ic_ready",  icReady, 0);
      checkOutput("rst_dc_ready",  dcReady, 0);
      checkOutput("rst_mem_valid", memReqValid, 0);
      checkOutput("rst_resp_vld",  {icRespValid, dcRespValid}, 0);
      checkOutput("rst_outstand",  outstanding, 0);
      checkOutput("rst_err",       respErr, 0);
      if (asyncSnapValid) checkOutput("async_reset_outputs", asyncSnap, 0);
      reqQ.delete();
      routeQ.delete();
      lastGrant = 1'b1;
      expErr    = 1'b0;
      icAcc     = 1'b0;
      dcAcc     = 1'b0;
    end else begin
      outs     = routeQ.size();
      slotFull = (reqQ.size() != 0);
      hs       = slotFull && memReady;
      pop      = respValid && (outs != 0);

      checkOutput("outstanding", outstanding, outs);
      checkOutput("mem_req_valid", memReqValid, slotFull);
      checkOutput("resp_err", respErr, expErr);
      if (slotFull) checkOutput("mem_req_addr", memReqAddr, reqQ[0].addr);

      // Response routing against the oldest issued request
      if (respValid && outs == 0) begin
        checkOutput("stray_ic_resp", icRespValid, 0);
        checkOutput("stray_dc_resp", dcRespValid, 0);
        expErr = 1'b1;
      end else if (respValid) begin
        id = routeQ.pop_front();
        checkOutput("ic_resp_valid", icRespValid, (id == 1'b0));
        checkOutput("dc_resp_valid", dcRespValid, (id == 1'b1));
        checkOutput("resp_data", respDataOut, respData);
      end else begin
        checkOutput("idle_resp_valid", {icRespValid, dcRespValid}, 0);
      end

      // Grant prediction: a new request may enter the slot if it is empty
      // and fewer than ORD_DEPTH transactions are outstanding, or if the
      // held request leaves this cycle and the resulting count has room.
      if (slotFull) canGrant = hs && ((outs + 1 - (pop ? 1 : 0)) < ORD_DEPTH);
      else          canGrant = (outs < ORD_DEPTH);
      expIc = 1'b0;
      expDc = 1'b0;
      if (canGrant) begin
        if (icValid && dcValid) begin
          if (lastGrant) expIc = 1'b1;
          else           expDc = 1'b1;
        end else if (icValid) expIc = 1'b1;
        else if (dcValid)     expDc = 1'b1;
      end
      checkOutput("ic_req_ready", icReady, expIc);
      checkOutput("dc_req_ready", dcReady, expDc);

      if (hs) begin
        r = reqQ.pop_front();
        routeQ.push_back(r.id);
      end
      if (expIc) begin
        reqQ.push_back('{id: 1'b0, addr: icAddr});
        lastGrant = 1'b0;
      end else if (expDc) begin
        reqQ.push_back('{id: 1'b1, addr: dcAddr});
        lastGrant = 1'b1;
      end
      icAcc = icReady;
      dcAcc = dcReady;
    end
  end

  // One cycle of randomised stimulus; requesters hold valid/addr until
  // accepted, responses only come while something is outstanding unless
  // stray responses are allowed.
  task automatic applyStimulus(input int pIc, input int pDc, input int pRdy,
                               input int pResp, input bit stray);
    @(posedge clk);
    #1;
    if (!icValid || icAcc) begin
      icValid = ($urandom_range(99) < pIc);
      icAddr  = ADDR_W'($urandom);
    end
    if (!dcValid || dcAcc) begin
      dcValid = ($urandom_range(99) < pDc);
      dcAddr  = ADDR_W'($urandom);
    end
    memReady  = ($urandom_range(99) < pRdy);
    respValid = ((routeQ.size() != 0) || stray) && ($urandom_range(99) < pResp);
    for (int i = 0; i < LINE_W / 32; i++) respData[i*32 +: 32] = $urandom;
  endtask

  initial begin
    reset     = 1'b1;
    icValid   = 1'b0;
    dcValid   = 1'b0;
    icAddr    = '0;
    dcAddr    = '0;
    memReady  = 1'b0;
    respValid = 1'b0;
    respData  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single I-cache request at 0x123 and its response
    icValid  = 1'b1;
    icAddr   = 26'h123;
    memReady = 1'b1;
    @(posedge clk); #1;
    icValid = 1'b0;
    @(posedge clk); #1;
    respValid = 1'b1;
    respData  = {8{32'hA5A5A5A5}};
    @(posedge clk); #1;
    respValid = 1'b0;
    repeat (2) @(posedge clk);

    // Both requesters continuously valid, memory always ready
    repeat (20) applyStimulus(100, 100, 100, 100, 1'b0);

    // Memory stalls with the slot full, then releases
    repeat (6) applyStimulus(100, 100, 0, 0, 1'b0);
    repeat (8) applyStimulus(100, 100, 100, 0, 1'b0);

    // Order FIFO full, then one response frees a single entry
    applyStimulus(100, 100, 100, 100, 1'b0);
    repeat (4) applyStimulus(100, 100, 100, 0, 1'b0);

    // Steady push/pop traffic across many pointer wraps
    repeat (30) applyStimulus(100, 100, 100, 100, 1'b0);
    repeat (2)  applyStimulus(0, 0, 100, 0, 1'b0);
    repeat (40) applyStimulus(60, 60, 100, 60, 1'b0);

    // Random traffic
    repeat (400) applyStimulus(70, 70, 70, 50, 1'b0);

    // Drain, then responses with nothing outstanding
    repeat (30) applyStimulus(0, 0, 100, 100, 1'b0);
    repeat (5)  applyStimulus(0, 0, 100, 100, 1'b1);
    repeat (5)  applyStimulus(0, 0, 100, 0, 1'b0);

    // Reset in the middle of traffic
    repeat (10) applyStimulus(100, 100, 100, 30, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    asyncSnap = {icReady, dcReady, memReqValid, icRespValid, dcRespValid,
                 respErr, outstanding};
    asyncSnapValid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    asyncSnapValid = 1'b0;
    icValid   = 1'b0;
    dcValid   = 1'b0;
    respValid = 1'b0;

    // Late responses from before the reset, then fresh traffic
    repeat (3)   applyStimulus(0, 0, 100, 100, 1'b1);
    repeat (100) applyStimulus(70, 70, 70, 50, 1'b0);

    @(posedge clk); #1;
    respValid = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one memory-side miss port between the I-cache refill path (requester 0) and the D-cache refill path (requester 1).
- Round-robin arbitration feeds a single registered output request slot.
- The memory side returns responses in issue order. A grant-order FIFO routes each response to the requester that issued it.
- Sits between the I-cache/D-cache controllers and the memory interface.

Parameters:
- ADDR_W, 26, block address width (tag+index bits).
- LINE_W, 256, refill line width in bits.
- ORD_DEPTH, 4, max outstanding memory transactions; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- ic_req_valid_i  in  1  I-cache miss request.
- ic_req_addr_i  in  ADDR_W  I-cache block address.
- ic_req_ready_o  out  1  I-cache request accepted this cycle.
- dc_req_valid_i  in  1  D-cache miss request.
- dc_req_addr_i  in  ADDR_W  D-cache block address.
- dc_req_ready_o  out  1  D-cache request accepted this cycle.
- mem_req_valid_o  out  1  request to memory.
- mem_req_addr_o  out  ADDR_W  request address.
- mem_req_ready_i  in  1  memory accepts request.
- mem_resp_valid_i  in  1  response valid (in order).
- mem_resp_data_i  in  LINE_W  response line.
- ic_resp_valid_o  out  1  response for I-cache.
- dc_resp_valid_o  out  1  response for D-cache.
- resp_data_o  out  LINE_W  response line, shared by both requesters.
- outstanding_o  out  $clog2(ORD_DEPTH)+1  outstanding transaction count.
- resp_err_o  out  1  sticky: response received with no outstanding transaction.

Behaviour:
- Reset values: all valid/ready outputs 0, outstanding_o 0, resp_err_o 0, order FIFO empty, last_grant=1 (so the I-cache wins the first tie), out slot empty. mem_req_addr_o and resp_data_o are don't-care under reset but must not be X after the first valid.
- Output slot state machine, two states:
  - EMPTY: arbitrate when (ic_req_valid_i|dc_req_valid_i) && count<ORD_DEPTH; on a win, latch the address, go to FULL.
  - FULL: mem_req_valid_o=1 with the address held stable. On mem_req_ready_i: push the requester ID into the order FIFO and count++.
    - Same cycle, if another arbitration win is possible (count+1<ORD_DEPTH, or a response pop this cycle frees an entry), reload and stay FULL.
    - Otherwise go to EMPTY.
- Arbitration: round-robin. Both valid → grant the requester != last_grant. Only one valid → grant it. last_grant updates on each grant.
- Ready: the granted requester's ready_o=1 combinationally, in the cycle its address is latched; at most one ready per cycle. Requesters hold valid/addr until ready.
- Request latency: request accepted cycle N → mem_req_valid_o at N+1.
- Response routing:
  - Combinational. With mem_resp_valid_i and FIFO non-empty, assert ic_resp_valid_o if head ID=0, else dc_resp_valid_o; pop head, count--.
  - resp_data_o = mem_resp_data_i.
- Simultaneous push (mem handshake) and pop (response) in one cycle: count unchanged; FIFO pointers both advance.
- Full: count==ORD_DEPTH → no grants; both ready_o=0; the slot stays EMPTY until a pop.
- Empty-FIFO response: drop it, no resp_valid asserted, set resp_err_o (cleared only by reset).
- Pointer wrap: modulo ORD_DEPTH. Count width distinguishes full from empty.
- Reset mid-transaction: all state clears immediately (async); in-flight memory responses arriving after reset deassert set resp_err_o.

Optional Feature:
- MEM_ARB_PERF_CNT_EN
- Defined: adds outputs ic_grant_cnt_o[31:0], dc_grant_cnt_o[31:0], full_stall_cnt_o[31:0].
  - Grant counters increment on each ready_o.
  - The stall counter increments on each cycle with any request valid && count==ORD_DEPTH.
  - All reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; no other behaviour changes.

Test Plan:
- Single I-cache request addr 0x123, mem_req_ready_i=1 → ic_req_ready_o at cycle 0, mem_req_valid_o addr 0x123 at cycle 1. A response with data 0xA5.. → ic_resp_valid_o=1, dc_resp_valid_o=0, outstanding 1→0.
- Both requesters valid continuously after reset, memory always ready → grants alternate IC, DC, IC, DC. In-order responses route to ic, dc, ic, dc.
- Memory ready held 0 for 5 cycles with the slot FULL → mem_req_addr_o stable, no further ready_o. On release, the next grant occurs in the same cycle as the handshake.
- Issue 4 requests with no responses (ORD_DEPTH=4) → outstanding_o=4 and both ready_o=0. One response → outstanding drops, a new grant is accepted, outstanding returns to 4.
- Push and pop in the same cycle at outstanding=2 → outstanding stays 2, and FIFO order is preserved across pointer wrap (≥9 transactions).
- Response with FIFO empty → no resp_valid, resp_err_o=1 and sticky. Assert reset mid-stream → all outputs 0 asynchronously.
